// File: rtl/dsp_add_pkg.sv
// Shared types and elaboration helpers for the pipelined signed adder tree.
// All helpers are constant functions used to size levels and locate their slices.
package dsp_add_pkg;

    localparam int MIN_INPUTS = 2;
    localparam int MAX_INPUTS = 32;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } side_t;

    function automatic int tree_depth(input int n);
        int d;
        d = 0;
        while ((1 << d) < n) d++;
        return d;
    endfunction

    // Elements present at tree level k (level 0 is the compensated operands).
    function automatic int level_count(input int n, input int k);
        return (n + (1 << k) - 1) >> k;
    endfunction

    // Bit offset of level k in the flattened level bus; level j elements are w0+j bits wide.
    function automatic int level_offset(input int n, input int w0, input int k);
        int off;
        off = 0;
        for (int j = 0; j < k; j++) off += level_count(n, j) * (w0 + j);
        return off;
    endfunction

    function automatic int add_latency(input int n, input int acc);
        return 1 + tree_depth(n) + ((acc != 0) ? 1 : 0);
    endfunction

    function automatic int min_out_width(input int n, input int in_width);
        return in_width + tree_depth(n) + 1;
    endfunction

endpackage

// File: rtl/dsp_add_tree_level.sv
// One registered pairwise adder level of the tree; each output is one bit wider than its inputs.
// Bubbles (valid=0) leave the data registers untouched so the final level holds the last result.
module dsp_add_tree_level
    import dsp_add_pkg::*;
#(
    parameter int N_IN = 2,
    parameter int W_IN = 19
) (
    input  logic                                    clk,
    input  logic                                    areset,
    input  logic                                    clken,
    input  logic                                    dsp_reset,
    input  logic [N_IN*W_IN-1:0]                    in_data,
    input  side_t                                   in_side,
    output logic [((N_IN+1)/2)*(W_IN+1)-1:0]        out_data,
    output side_t                                   out_side
);

    localparam int N_OUT = (N_IN + 1) / 2;
    localparam int W_OUT = W_IN + 1;
    localparam int W_PAD = 2 * N_OUT * W_IN;

    logic [W_PAD-1:0]       pad;
    logic [N_OUT*W_OUT-1:0] sum_d, sum_q;
    side_t                  side_q;

    // An odd trailing element is paired with a zero slot, i.e. passed through unchanged.
    assign pad = W_PAD'(in_data);

    always_comb begin
        sum_d = '0;
        for (int i = 0; i < N_OUT; i++) begin
            sum_d[i*W_OUT +: W_OUT] = W_OUT'(signed'(pad[(2*i)*W_IN +: W_IN]))
                                    + W_OUT'(signed'(pad[(2*i+1)*W_IN +: W_IN]));
        end
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            sum_q  <= '0;
            side_q <= '0;
        end else if (clken) begin
            if (dsp_reset) begin
                side_q <= '0;
            end else begin
                side_q <= in_side;
                if (in_side.valid) begin
                    sum_q <= sum_d;
                end
            end
        end
    end

    assign out_data = sum_q;
    assign out_side = side_q;

endmodule

// File: rtl/dsp_add_tree_cin.sv
// N-input signed adder tree with per-operand compensate carry, valid/first/last sideband
// and an optional group accumulator with sticky signed-overflow detection.
module dsp_add_tree_cin
    import dsp_add_pkg::*;
#(
    parameter int NUM_INPUTS = 8,
    parameter int IN_WIDTH   = 18,
    parameter int OUT_WIDTH  = 48,
    parameter int ACCUMULATE = 0
) (
    input  logic                           clk,
    input  logic                           areset,
    input  logic                           clken,
    input  logic                           dsp_reset,
    input  logic [NUM_INPUTS*IN_WIDTH-1:0] op,
    input  logic [NUM_INPUTS-1:0]          cin,
    input  logic                           in_valid,
    input  logic                           in_first,
    input  logic                           in_last,
    output logic [OUT_WIDTH-1:0]           result,
    output logic                           out_valid,
    output logic                           out_ovf
);

    localparam int D       = tree_depth(NUM_INPUTS);
    localparam int W0      = IN_WIDTH + 1;
    localparam int W_SUM   = W0 + D;
    localparam int BUS_W   = level_offset(NUM_INPUTS, W0, D + 1);
    localparam int SUM_OFF = level_offset(NUM_INPUTS, W0, D);

    if (NUM_INPUTS < MIN_INPUTS || NUM_INPUTS > MAX_INPUTS) begin : g_bad_num_inputs
        $error("dsp_add_tree_cin: NUM_INPUTS out of range");
    end
    if (OUT_WIDTH < min_out_width(NUM_INPUTS, IN_WIDTH)) begin : g_bad_out_width
        $error("dsp_add_tree_cin: OUT_WIDTH too narrow for the tree sum");
    end

    logic [NUM_INPUTS*W0-1:0] t_d, t_q;
    side_t                    side0_d, side0_q;
    logic [BUS_W-1:0]         lvl_bus;
    side_t [D:0]              side_bus;
    logic [OUT_WIDTH-1:0]     sum_ext;
    side_t                    tree_side;

    // Stage 0: fold each compensate carry into its sign-extended operand.
    always_comb begin
        t_d = '0;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            t_d[i*W0 +: W0] = W0'(signed'(op[i*IN_WIDTH +: IN_WIDTH])) + W0'(cin[i]);
        end
    end

    assign side0_d = '{valid: in_valid, first: in_first, last: in_last};

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            t_q     <= '0;
            side0_q <= '0;
        end else if (clken) begin
            if (dsp_reset) begin
                side0_q <= '0;
            end else begin
                side0_q <= side0_d;
                if (in_valid) begin
                    t_q <= t_d;
                end
            end
        end
    end

    assign lvl_bus[NUM_INPUTS*W0-1:0] = t_q;
    assign side_bus[0]                = side0_q;

    for (genvar k = 0; k < D; k++) begin : g_lvl
        localparam int N_K   = level_count(NUM_INPUTS, k);
        localparam int W_K   = W0 + k;
        localparam int N_NX  = level_count(NUM_INPUTS, k + 1);
        localparam int OFF_K = level_offset(NUM_INPUTS, W0, k);
        localparam int OFF_N = level_offset(NUM_INPUTS, W0, k + 1);

        dsp_add_tree_level #(
            .N_IN (N_K),
            .W_IN (W_K)
        ) u_level (
            .clk       (clk),
            .areset    (areset),
            .clken     (clken),
            .dsp_reset (dsp_reset),
            .in_data   (lvl_bus[OFF_K +: N_K*W_K]),
            .in_side   (side_bus[k]),
            .out_data  (lvl_bus[OFF_N +: N_NX*(W_K+1)]),
            .out_side  (side_bus[k+1])
        );
    end

    assign sum_ext   = OUT_WIDTH'(signed'(lvl_bus[SUM_OFF +: W_SUM]));
    assign tree_side = side_bus[D];

    if (ACCUMULATE != 0) begin : g_acc
        logic [OUT_WIDTH-1:0] acc_q, acc_d, base, res_q;
        logic                 ovf_q, ovf_d, add_ovf;
        logic                 out_valid_q, out_ovf_q;

        // A first beat restarts from zero, so it can never overflow on its own.
        always_comb begin
            base    = tree_side.first ? '0 : acc_q;
            acc_d   = base + sum_ext;
            add_ovf = (base[OUT_WIDTH-1] == sum_ext[OUT_WIDTH-1])
                   && (acc_d[OUT_WIDTH-1] != base[OUT_WIDTH-1]);
            ovf_d   = (tree_side.first ? 1'b0 : ovf_q) | add_ovf;
        end

        always_ff @(posedge clk or posedge areset) begin
            if (areset) begin
                acc_q       <= '0;
                ovf_q       <= 1'b0;
                res_q       <= '0;
                out_valid_q <= 1'b0;
                out_ovf_q   <= 1'b0;
            end else if (clken) begin
                if (dsp_reset) begin
                    acc_q       <= '0;
                    ovf_q       <= 1'b0;
                    out_valid_q <= 1'b0;
                    out_ovf_q   <= 1'b0;
                end else begin
                    out_valid_q <= tree_side.valid && tree_side.last;
                    if (tree_side.valid) begin
                        acc_q <= acc_d;
                        ovf_q <= ovf_d;
                        if (tree_side.last) begin
                            res_q     <= acc_d;
                            out_ovf_q <= ovf_d;
                        end
                    end
                end
            end
        end

        assign result    = res_q;
        assign out_valid = out_valid_q;
        assign out_ovf   = out_ovf_q;
    end else begin : g_noacc
        assign result    = sum_ext;
        assign out_valid = tree_side.valid;
        assign out_ovf   = 1'b0;
    end

endmodule

// File: tb/tb_dsp_add_tree_cin.sv
// Directed checks of dsp_add_tree_cin in four configurations sharing clock and control.
module tb_dsp_add_tree_cin;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset, clken, dsp_reset;
  int n_checks = 0;
  int n_fail   = 0;

  // u8: N=8, IN=18, OUT=48, no accumulate
  logic [8*18-1:0] op8;
  logic [7:0]      cin8;
  logic            v8;
  logic [47:0]     r8;
  logic            ov8, of8;

  // u5: N=5, IN=18, OUT=48, no accumulate
  logic [5*18-1:0] op5;
  logic [4:0]      cin5;
  logic            v5;
  logic [47:0]     r5;
  logic            ov5, of5;

  // ua: N=8, IN=18, OUT=48, accumulate
  logic [8*18-1:0] opa;
  logic [7:0]      cina;
  logic            va, fa, la;
  logic [47:0]     ra;
  logic            ova, ofa;

  // uo: N=2, IN=22, OUT=24, accumulate
  logic [2*22-1:0] opo;
  logic [1:0]      cino;
  logic            vo, fo, lo;
  logic [23:0]     ro;
  logic            ovo, ofo;

  logic            zero_bit;

  dsp_add_tree_cin #(.NUM_INPUTS(8), .IN_WIDTH(18), .OUT_WIDTH(48), .ACCUMULATE(0)) u8 (
    .clk(clk), .areset(areset), .clken(clken), .dsp_reset(dsp_reset),
    .op(op8), .cin(cin8), .in_valid(v8), .in_first(zero_bit), .in_last(zero_bit),
    .result(r8), .out_valid(ov8), .out_ovf(of8)
  );

  dsp_add_tree_cin #(.NUM_INPUTS(5), .IN_WIDTH(18), .OUT_WIDTH(48), .ACCUMULATE(0)) u5 (
    .clk(clk), .areset(areset), .clken(clken), .dsp_reset(dsp_reset),
    .op(op5), .cin(cin5), .in_valid(v5), .in_first(zero_bit), .in_last(zero_bit),
    .result(r5), .out_valid(ov5), .out_ovf(of5)
  );

  dsp_add_tree_cin #(.NUM_INPUTS(8), .IN_WIDTH(18), .OUT_WIDTH(48), .ACCUMULATE(1)) ua (
    .clk(clk), .areset(areset), .clken(clken), .dsp_reset(dsp_reset),
    .op(opa), .cin(cina), .in_valid(va), .in_first(fa), .in_last(la),
    .result(ra), .out_valid(ova), .out_ovf(ofa)
  );

  dsp_add_tree_cin #(.NUM_INPUTS(2), .IN_WIDTH(22), .OUT_WIDTH(24), .ACCUMULATE(1)) uo (
    .clk(clk), .areset(areset), .clken(clken), .dsp_reset(dsp_reset),
    .op(opo), .cin(cino), .in_valid(vo), .in_first(fo), .in_last(lo),
    .result(ro), .out_valid(ovo), .out_ovf(ofo)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set8(input int val, input logic [7:0] c);
    for (int i = 0; i < 8; i++) op8[i*18 +: 18] = 18'(val);
    cin8 = c;
    v8   = 1'b1;
  endtask

  task automatic set5(input int a0, input int a1, input int a2, input int a3, input int a4,
                      input logic [4:0] c);
    op5[0*18 +: 18] = 18'(a0);
    op5[1*18 +: 18] = 18'(a1);
    op5[2*18 +: 18] = 18'(a2);
    op5[3*18 +: 18] = 18'(a3);
    op5[4*18 +: 18] = 18'(a4);
    cin5 = c;
    v5   = 1'b1;
  endtask

  task automatic seta(input int a0, input int a1, input logic c0, input logic f, input logic l);
    opa = '0;
    opa[0*18 +: 18] = 18'(a0);
    opa[1*18 +: 18] = 18'(a1);
    cina = {7'b0, c0};
    va = 1'b1;
    fa = f;
    la = l;
  endtask

  task automatic seto(input int a0, input int a1, input logic [1:0] c, input logic f, input logic l);
    opo[0*22 +: 22] = 22'(a0);
    opo[1*22 +: 22] = 22'(a1);
    cino = c;
    vo = 1'b1;
    fo = f;
    lo = l;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    areset = 1'b1; clken = 1'b1; dsp_reset = 1'b0; zero_bit = 1'b0;
    op8 = '0; cin8 = '0; v8 = 1'b0;
    op5 = '0; cin5 = '0; v5 = 1'b0;
    opa = '0; cina = '0; va = 1'b0; fa = 1'b0; la = 1'b0;
    opo = '0; cino = '0; vo = 1'b0; fo = 1'b0; lo = 1'b0;

    // Reset state
    step(); step();
    chk("rst_r8", 64'(signed'(r8)), 0);
    chk("rst_ov8", ov8, 0);
    chk("rst_of8", of8, 0);
    chk("rst_ova", ova, 0);
    chk("rst_ofa", ofa, 0);
    chk("rst_ra", 64'(signed'(ra)), 0);
    areset = 1'b0;
    step();

    // 1: all ones, single beat, latency 4
    set8(1, 8'h00);
    step(); v8 = 1'b0;
    chk("t1_lat1", ov8, 0);
    step(); chk("t1_lat2", ov8, 0);
    step(); chk("t1_lat3", ov8, 0);
    step(); chk("t1_valid", ov8, 1); chk("t1_result", 64'(signed'(r8)), 8);
    step(); chk("t1_pulse", ov8, 0); chk("t1_hold", 64'(signed'(r8)), 8);
    chk("t1_ovf0", of8, 0);

    // 2: most negative operands with carry on every lane
    set8(-131072, 8'hFF);
    step(); v8 = 1'b0;
    step(); step(); step();
    chk("t2_valid", ov8, 1);
    chk("t2_result", 64'(signed'(r8)), -1048568);

    // 3: N=5, back-to-back beats
    set5(100, -3, 7, 0, -50, 5'b00100);
    step(); set5(1, 2, 3, 4, 5, 5'b11111);
    step(); set5(-131072, -131072, -131072, -131072, -131072, 5'b00000);
    step(); v5 = 1'b0;
    step(); chk("t3_a_valid", ov5, 1); chk("t3_a_result", 64'(signed'(r5)), 55);
    step(); chk("t3_b_valid", ov5, 1); chk("t3_b_result", 64'(signed'(r5)), 20);
    step(); chk("t3_c_valid", ov5, 1); chk("t3_c_result", 64'(signed'(r5)), -655360);
    step(); chk("t3_idle", ov5, 0); chk("t3_hold", 64'(signed'(r5)), -655360);

    // 4: accumulate groups 10 + -4 + 20, then single-beat 7, then first-less beat 3
    seta(10, 0, 1'b0, 1'b1, 1'b0);
    step(); seta(-5, 0, 1'b1, 1'b0, 1'b0);
    step(); seta(10, 10, 1'b0, 1'b0, 1'b1);
    step(); seta(3, 3, 1'b1, 1'b1, 1'b1);
    step(); va = 1'b0;
    step(); chk("t4_no_pulse_b1", ova, 0);
    step(); chk("t4_no_pulse_b2", ova, 0);
    step(); chk("t4_grp_valid", ova, 1); chk("t4_grp_result", 64'(signed'(ra)), 26);
    chk("t4_grp_ovf", ofa, 0);
    step(); chk("t4_single_valid", ova, 1); chk("t4_single_result", 64'(signed'(ra)), 7);
    step(); chk("t4_idle", ova, 0); chk("t4_hold", 64'(signed'(ra)), 7);
    seta(3, 0, 1'b0, 1'b0, 1'b1);
    step(); va = 1'b0;
    step(); step(); step(); step();
    chk("t4_nofirst_valid", ova, 1);
    chk("t4_nofirst_result", 64'(signed'(ra)), 10);

    // 5a: clken low for 3 cycles with two beats in flight
    set8(2, 8'h00);
    step(); set8(-1, 8'h0F);
    step(); v8 = 1'b0; clken = 1'b0;
    step(); chk("t5_stall1", ov8, 0);
    step(); chk("t5_stall2", ov8, 0);
    step(); clken = 1'b1;
    step(); chk("t5_pre", ov8, 0);
    step(); chk("t5_p_valid", ov8, 1); chk("t5_p_result", 64'(signed'(r8)), 16);
    step(); chk("t5_q_valid", ov8, 1); chk("t5_q_result", 64'(signed'(r8)), -4);
    step(); chk("t5_done", ov8, 0);

    // 5b: dsp_reset discards in-flight beats and the beat presented with it
    set8(2, 8'h00);
    step(); set8(-1, 8'h0F);
    step(); set8(5, 8'h00); dsp_reset = 1'b1;
    step(); dsp_reset = 1'b0; v8 = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("t5_flush_quiet", ov8, 0);
      step();
    end
    chk("t5_flush_hold", 64'(signed'(r8)), -4);
    set8(1, 8'h00);
    step(); v8 = 1'b0;
    step(); step(); step();
    chk("t5_post_valid", ov8, 1);
    chk("t5_post_result", 64'(signed'(r8)), 8);

    // 6: 24-bit accumulator wraps on 2^22 + 2^22; next group clears the flag
    seto(2097151, 2097151, 2'b11, 1'b1, 1'b0);
    step(); seto(2097151, 2097151, 2'b11, 1'b0, 1'b1);
    step(); vo = 1'b0;
    step(); chk("t6_pre", ovo, 0);
    step(); chk("t6_valid", ovo, 1);
    chk("t6_result", 64'(signed'(ro)), -8388608);
    chk("t6_ovf", ofo, 1);
    seto(5, 0, 2'b00, 1'b1, 1'b1);
    step(); vo = 1'b0;
    step(); step();
    chk("t6_next_valid", ovo, 1);
    chk("t6_next_result", 64'(signed'(ro)), 5);
    chk("t6_next_ovf", ofo, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsp_add_tree_cin.md
Name: dsp_add_tree_cin

Overview:
- Parametrised, fully pipelined N-input signed adder tree with per-input compensate carry.
- Each carry is the sign-correction bit from the low segment of a 2x SIMD INT9xUINT8 product.
- Generalises the fixed 8-input cascade adder: arbitrary input count and widths, valid/first/last sideband, optional accumulate-over-group mode with overflow detection.
- Sits between the SIMD multiplier array and the bicubic interpolation output normaliser.

Parameters:
- NUM_INPUTS, 8, number of operands (2..32).
- IN_WIDTH, 18, signed operand width.
- OUT_WIDTH, 48, signed result/accumulator width (>= IN_WIDTH+ceil(log2(NUM_INPUTS))+1).
- ACCUMULATE, 0, 1 adds an accumulator stage that sums successive beats from in_first to in_last.

Ports:
- clk  in  1  clock.
- areset  in  1  asynchronous, active-high reset.
- clken  in  1  global pipeline enable; low freezes every register.
- dsp_reset  in  1  synchronous flush of data and valid, qualified by clken.
- op  in  NUM_INPUTS x IN_WIDTH  signed operands, packed, op[0] in the LSBs.
- cin  in  NUM_INPUTS  compensate carry per operand (0 for unused).
- in_valid  in  1  beat valid.
- in_first  in  1  first beat of group (ACCUMULATE=1 only).
- in_last  in  1  last beat of group (ACCUMULATE=1 only).
- result  out  OUT_WIDTH  signed sum.
- out_valid  out  1  result valid.
- out_ovf  out  1  accumulator signed overflow occurred in this group (always 0 when ACCUMULATE=0).

Behaviour:
- Reset: areset asynchronously clears all pipeline registers; result=0, out_valid=0, out_ovf=0.
- Stage 0 (registered):
  - t_i = sext(op[i]) + cin[i], width IN_WIDTH+1.
  - Valid, first and last are captured alongside.
- Stages 1..D, where D = ceil(log2(NUM_INPUTS)):
  - Pairwise registered adders, each level one bit wider.
  - An odd element at any level is passed through a register unchanged.
- Latency: L = 1 + D cycles of clken=1 (NUM_INPUTS=8 -> 4; NUM_INPUTS=5 -> 4).
- ACCUMULATE=1 adds one accumulator stage, so latency is L+1 measured to the last beat.
- Accumulate mode:
  - Beat with first=1: acc = tree_sum.
  - Other valid beats: acc += tree_sum, two's-complement wrap.
  - out_valid pulses only for the beat carrying last=1; result is the accumulated value.
  - first and last both set -> single-beat group.
  - Beats arriving with no preceding first add into the current acc.
- Overflow: sticky flag set when an add's signed result leaves the OUT_WIDTH range; cleared on first; presented as out_ovf with the group's result.
- Non-accumulate mode: out_valid follows in_valid delayed by L; first and last are ignored.
- clken=0 holds all data, valid and sticky state. No beat is lost or duplicated; latency stretches by exactly the stalled cycles.
- dsp_reset=1 with clken=1:
  - Clears all valid bits, the accumulator and the sticky ovf.
  - Beats in flight are discarded: no out_valid for them.
  - A beat presented in the same cycle is also discarded.
- in_valid=0 beats propagate as bubbles and never change the accumulator.
- Invalid-beat data is don't-care, but result holds its last value when out_valid=0.
- Simultaneous first with last in ACCUMULATE mode and dsp_reset: reset wins.

Decomposition:
- Package dsp_add_pkg:
  - function tree_depth(n) = ceil(log2 n).
  - function add_latency(n, acc).
  - localparam range checks.
- Sub-module dsp_add_tree_level: one registered pairwise adder level, parametrised by element count and input width, with odd pass-through and clken/dsp_reset handling.
- Generate D instances of it; the accumulator stays in the top.

Test Plan:
1. N=8, all op=1, cin=0, single valid beat -> result=8, out_valid exactly 4 cycles later for one cycle.
2. N=8, all op=-131072, cin=8'hFF -> result=-1048568 (8 x -131071).
3. N=5, op={100,-3,7,0,-50}, cin=5'b00100 -> result=55 after 4 cycles; back-to-back beats every cycle yield one result per cycle, in order.
4. ACCUMULATE=1: three beats summing to 10, -4 and 20 (first on beat 1, last on beat 3) -> single out_valid 5 cycles after beat 3, result=26, out_ovf=0. A following single-beat group (first and last both set) with sum 7 -> result=7.
5. clken low for 3 cycles while two beats are in flight -> out_valid for each delayed by exactly 3; values unchanged. dsp_reset pulsed instead -> no out_valid for those beats.
6. ACCUMULATE=1, OUT_WIDTH=24, two beats of sum 2^22 each -> result=-2^23 (wrapped), out_ovf=1. The next group starting with first -> out_ovf=0.
